// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_pkg
//  Description : Shared constants and types for the general-register bank
//                write path: bank geometry, opcodes, FIFO entry layout.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_bank_pkg;

   // Bank geometry
   localparam int NREG   = 16;
   localparam int ADDR_W = 5;   // same width as the read select; 16..31 invalid
   localparam int OP_W   = 2;
   localparam int DATA_W = 16;

   // Write opcodes
   typedef enum logic [OP_W-1:0] {
      OP_LOAD = 2'b00,
      OP_SET  = 2'b01,
      OP_CLR  = 2'b10,
      OP_INC  = 2'b11
   } op_e;

   // FIFO entry layout, MSB first: {addr, op, data}
   localparam int ENTRY_ADDR_W = ADDR_W;
   localparam int ENTRY_OP_W   = OP_W;

   function automatic int entry_w(input int data_w);
      return ENTRY_ADDR_W + ENTRY_OP_W + data_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo2_wr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo2_wr
//  Description : Two-entry in-order synchronous FIFO. Exposes the registered
//                occupancy and the head entry; slot 0 is always the head.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo2_wr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] ent0_q, ent0_d;
   logic [WIDTH-1:0] ent1_q, ent1_d;
   logic             push_w, pop_w;
   logic [1:0]       wr_idx_w;

   // Requests are qualified against the current occupancy so the FIFO can
   // never overflow or underflow regardless of what the caller asks for.
   assign push_w   = push_i && (count_q != 2'd2);
   assign pop_w    = pop_i  && (count_q != 2'd0);
   assign wr_idx_w = count_q - {1'b0, pop_w};

   // Next-state: shift on pop, then drop a new entry into the first free slot
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q + {1'b0, push_w} - {1'b0, pop_w};
      if (pop_w) begin
         ent0_d = ent1_q;
      end
      if (push_w) begin
         if (wr_idx_w == 2'd0) begin
            ent0_d = din_i;
         end else begin
            ent1_d = din_i;
         end
      end
   end

   // Storage and occupancy; a reset discards any buffered entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         ent0_q  <= '0;
         ent1_q  <= '0;
      end else begin
         count_q <= count_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = ent0_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank_wr.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_wr
//  Description : Write side of the 16-entry general-register bank. Requests
//                are buffered in a 2-entry FIFO and committed one per cycle
//                as LOAD / SET / CLR / INC on the addressed register.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank_wr
   import reg_bank_pkg::*;
#(
   parameter int N = DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [OP_W-1:0]   wr_op,
   input  logic [N-1:0]      wr_data,
   output logic [N-1:0]      R_0,
   output logic [N-1:0]      R_1,
   output logic [N-1:0]      R_2,
   output logic [N-1:0]      R_3,
   output logic [N-1:0]      R_4,
   output logic [N-1:0]      R_5,
   output logic [N-1:0]      R_6,
   output logic [N-1:0]      R_7,
   output logic [N-1:0]      R_8,
   output logic [N-1:0]      R_9,
   output logic [N-1:0]      R_10,
   output logic [N-1:0]      R_11,
   output logic [N-1:0]      R_12,
   output logic [N-1:0]      R_13,
   output logic [N-1:0]      R_14,
   output logic [N-1:0]      R_15,
   output logic              wr_done,
   output logic              err_addr
);

   localparam int ENTRY_W = entry_w(N);

   logic [1:0]          fifo_cnt_w;
   logic [ENTRY_W-1:0]  push_ent_w;
   logic [ENTRY_W-1:0]  head_ent_w;
   logic                push_w;
   logic                pop_w;
   logic [ADDR_W-1:0]   head_addr_w;
   op_e                 head_op_w;
   logic [N-1:0]        head_data_w;
   logic                addr_ok_w;
   logic [NREG-1:0]     we_w;
   logic [N-1:0]        cur_val_w;
   logic [N-1:0]        new_val_w;
   logic [N-1:0]        regs_q [NREG];
   logic                done_q;
   logic                err_q;

   // Ready depends only on the registered occupancy
   assign wr_ready   = (fifo_cnt_w != 2'd2);
   assign push_w     = wr_valid && wr_ready;
   assign push_ent_w = {wr_addr, wr_op, wr_data};

   // The commit stage never stalls: whatever is at the head goes this edge
   assign pop_w = (fifo_cnt_w != 2'd0);

   fifo2_wr #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_w),
      .din_i   (push_ent_w),
      .pop_i   (pop_w),
      .count_o (fifo_cnt_w),
      .head_o  (head_ent_w)
   );

   assign head_addr_w = head_ent_w[ENTRY_W-1 -: ADDR_W];
   assign head_op_w   = op_e'(head_ent_w[N +: OP_W]);
   assign head_data_w = head_ent_w[N-1:0];
   assign addr_ok_w   = (head_addr_w < ADDR_W'(NREG));

   // Read the current value of the target register for read-modify-write
   assign cur_val_w = regs_q[head_addr_w[3:0]];

   // Commit ALU: one shared datapath for the head entry
   always_comb begin
      new_val_w = cur_val_w;
      case (head_op_w)
         OP_LOAD: new_val_w = head_data_w;
         OP_SET:  new_val_w = cur_val_w | head_data_w;
         OP_CLR:  new_val_w = cur_val_w & ~head_data_w;
         OP_INC:  new_val_w = cur_val_w + {{(N-1){1'b0}}, 1'b1};
         default: new_val_w = cur_val_w;
      endcase
   end

   // Address decoder: one-hot enable, all-zero for an out-of-range index
   always_comb begin
      we_w = '0;
      if (pop_w && addr_ok_w) begin
         we_w = NREG'(1) << head_addr_w[3:0];
      end
   end

   // Register array; each register loads the ALU result when selected
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         // Per-register storage with write enable
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               regs_q[gi] <= '0;
            end else if (we_w[gi]) begin
               regs_q[gi] <= new_val_w;
            end
         end
      end
   endgenerate

   // Status pulses, high for the cycle after the commit edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= pop_w &&  addr_ok_w;
         err_q  <= pop_w && !addr_ok_w;
      end
   end

   assign wr_done  = done_q;
   assign err_addr = err_q;

   assign R_0  = regs_q[0];
   assign R_1  = regs_q[1];
   assign R_2  = regs_q[2];
   assign R_3  = regs_q[3];
   assign R_4  = regs_q[4];
   assign R_5  = regs_q[5];
   assign R_6  = regs_q[6];
   assign R_7  = regs_q[7];
   assign R_8  = regs_q[8];
   assign R_9  = regs_q[9];
   assign R_10 = regs_q[10];
   assign R_11 = regs_q[11];
   assign R_12 = regs_q[12];
   assign R_13 = regs_q[13];
   assign R_14 = regs_q[14];
   assign R_15 = regs_q[15];

endmodule
`default_nettype wire
